// File: rtl/uart_rx_ctrl.sv
// Sequencer between the bus side and the UART receive path: programs the brg
// divisor (high then low byte) and moves received bytes into a small FIFO.
module uart_rx_ctrl #(
  parameter int          DEPTH       = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'h028B,
  localparam int         CW          = $clog2(DEPTH + 1),
  localparam int         AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_cfg_req,
  input  logic [15:0]   i_cfg_div,
  output logic          o_cfg_busy,
  output logic [1:0]    o_ioaddr_brg,
  output logic [7:0]    o_brg_bus,
  input  logic          i_rda,
  input  logic [7:0]    i_rx_data,
  output logic          o_iocs,
  output logic          o_iorw,
  input  logic          i_pop,
  output logic [7:0]    o_data,
  output logic          o_valid,
  output logic [CW-1:0] o_count,
  output logic          o_overflow,
  input  logic          i_clr_ovf
);

  typedef enum logic [2:0] {CFG_HI, CFG_LO, IDLE, READ, GAP} state_e;

  state_e          state_q, state_d;
  logic [15:0]     div_q, div_d, pdiv_q, pdiv_d;
  logic            pend_q, pend_d;
  logic [1:0]      addr_q, addr_d;
  logic [7:0]      bus_q, bus_d;
  logic            rd_q, rd_d;
  logic            busy_q, busy_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            push, pop, wr, full;

  // Sequencer: next state plus registered bus outputs decoded from the current state.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    pdiv_d  = pdiv_q;
    pend_d  = pend_q;
    case (state_q)
      CFG_HI: state_d = CFG_LO;
      CFG_LO, IDLE: begin
        if (pend_q) begin
          state_d = CFG_HI;
          div_d   = pdiv_q;
          pend_d  = 1'b0;
        end else if (state_q == CFG_LO) begin
          state_d = IDLE;
        end else if (i_rda) begin
          state_d = READ;
        end
      end
      READ:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A request arriving while the previous one is consumed still leaves pend set.
    if (i_cfg_req) begin
      pend_d = 1'b1;
      pdiv_d = i_cfg_div;
    end

    addr_d = 2'b00;
    bus_d  = 8'hFF;
    rd_d   = 1'b0;
    case (state_q)
      CFG_HI: begin addr_d = 2'b11; bus_d = div_q[15:8]; end
      CFG_LO: begin addr_d = 2'b10; bus_d = div_q[7:0];  end
      READ:   rd_d = 1'b1;
      default: ;
    endcase
    busy_d = (state_q == CFG_HI) || (state_q == CFG_LO) || pend_q;
  end

  // FIFO: a full FIFO still accepts a push when a pop frees the head that cycle.
  always_comb begin
    push   = (state_q == READ);
    full   = (cnt_q == CW'(DEPTH));
    pop    = i_pop && (cnt_q != '0);
    wr     = push && (!full || pop);
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (wr) begin
      mem_d[wptr_q] = i_rx_data;
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop) rptr_d = rptr_q + AW'(1);
    case ({wr, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: ;
    endcase
    if (i_clr_ovf) ovf_d = 1'b0;
    if (push && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CFG_HI;
      div_q   <= DEFAULT_DIV;
      pdiv_q  <= DEFAULT_DIV;
      pend_q  <= 1'b0;
      addr_q  <= 2'b00;
      bus_q   <= 8'hFF;
      rd_q    <= 1'b0;
      busy_q  <= 1'b1;
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      pdiv_q  <= pdiv_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      bus_q   <= bus_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_ioaddr_brg = addr_q;
  assign o_brg_bus    = bus_q;
  assign o_iocs       = rd_q;
  assign o_iorw       = rd_q;
  assign o_cfg_busy   = busy_q;
  assign o_data       = mem_q[rptr_q];
  assign o_valid      = (cnt_q != '0);
  assign o_count      = cnt_q;
  assign o_overflow   = ovf_q;

endmodule
